data_mem_responder: RTL and testbench
=====================================

// Module: data_mem_responder
// PURPOSE
//  Memory-side responder for datapath load/store requests. Replaces the zero-latency DataMemory model.
//  Accepts one request at a time over a valid/ready handshake and applies a configurable wait-state count.
//  Returns read data or a write acknowledgement over a second valid/ready handshake.
//  Byte-addressed, big-endian (MIPS); supports byte, half and word accesses, with sign/zero extension on loads.
// PARAMETERS
//  DEPTH_BYTES  1024  storage size in bytes; must be a power of 2 and a multiple of 4
//  WAIT_CYCLES  1     extra cycles between accept and response, range 0..15
// PORTS
//  clk         in   1   single clock, rising edge
//  rst         in   1   synchronous, active-high reset
//  req_valid   in   1   request present
//  req_ready   out  1   responder can accept; high only in IDLE
//  req_write   in   1   1 = store, 0 = load
//  req_size    in   2   00 byte, 01 half, 10 word, 11 illegal
//  req_signed  in   1   loads only: 1 = sign-extend, 0 = zero-extend
//  req_addr    in   32  byte address
//  req_wdata   in   32  store data, right-justified (byte in [7:0], half in [15:0])
//  rsp_valid   out  1   response present
//  rsp_ready   in   1   datapath accepts response
//  rsp_rdata   out  32  load result, extended to 32 bits; 0 for stores and for errors
//  rsp_err     out  1   misaligned, out of range, or illegal size
//  busy        out  1   state != IDLE
// BEHAVIOUR
//  Reset: state=IDLE; req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, busy=0.
//   - Reset does not clear storage; storage is zero-initialised at time 0.
//  FSM: IDLE -> WAIT -> RESP -> IDLE.
//   - IDLE: on req_valid&&req_ready, latch write/size/signed/addr/wdata and load cnt=WAIT_CYCLES.
//     Go to WAIT if WAIT_CYCLES>0, otherwise go to RESP.
//   - WAIT: cnt decrements each cycle; when cnt==1, go to RESP.
//   - RESP: rsp_valid=1; hold rsp_rdata/rsp_err stable until rsp_ready. On rsp_ready, go to IDLE.
//  Commit point: the access happens on the edge that enters RESP.
//   - Store bytes are written and load data is captured into rsp_rdata on that edge.
//   - A load issued after a store always sees the stored data.
//  Latency: accept at edge N -> rsp_valid high after edge N+1+WAIT_CYCLES (minimum 1 cycle).
//  Response handshake: rsp_valid&&rsp_ready in RESP completes the transfer.
//   - req_ready rises the cycle after; there is no accept in the same cycle as a response.
//  Errors, checked on latched fields:
//   - half with addr[0]=1; word with addr[1:0]!=0; size==11; addr>=DEPTH_BYTES.
//   - Effect: rsp_err=1, rsp_rdata=0, no storage change.
//  Big-endian lanes: byte at addr A is bits [31:24] of the word at A&~3 when A[1:0]=0.
//   - Half at A[1]=0 occupies [31:16].
//  Loads: byte/half are extended per req_signed; word ignores req_signed.
//  Stores: only the addressed bytes change; other bytes in the word are preserved.
//  Reset mid-operation (WAIT or RESP): transaction is dropped.
//   - A store not yet committed is never written.
//   - Next cycle: IDLE, req_ready=1.
//  req_* inputs are ignored while not IDLE; they need not stay stable after accept.
// STRUCTURE
//  Shared package mem_pkg:
//   - SIZE_BYTE/SIZE_HALF/SIZE_WORD localparams
//   - state encoding IDLE/WAIT/RESP
//   - misalign-check function
//  Sub-module mem_lane_align (combinational):
//   - store: size + addr[1:0] + wdata -> 4-bit byte enable + lane-shifted word
//   - load: word + addr[1:0] + size + signed -> extended result
//  Top level holds FSM, wait counter, request latches and byte array.
// TESTING (WAIT_CYCLES=1 unless noted)
//  1 sw 0xDEADBEEF @0x10, then lw @0x10 -> rdata 0xDEADBEEF, err 0;
//    rsp_valid 2 cycles after each accept.
//  2 lb @0x10 signed -> 0xFFFFFFDE; lbu @0x13 -> 0x000000EF;
//    lh @0x12 signed -> 0xFFFFBEEF; lhu @0x10 -> 0x0000DEAD.
//  3 sb 0x55 @0x11, then lw @0x10 -> 0xDE55BEEF.
//  4 lw @0x12 -> err 1, rdata 0; sw 0x1 @0x21 -> err 1, and lw @0x20 is unchanged;
//    lw @0x400 -> err 1; size 11 -> err 1.
//  5 rsp_ready low for 3 cycles -> rsp_valid, rsp_rdata, rsp_err stable; req_ready 0 throughout.
//  6 WAIT_CYCLES=3: sw 0xCAFEF00D @0x8, rst pulsed in WAIT -> req_ready 1 next cycle;
//    lw @0x8 returns prior value; WAIT_CYCLES=0 -> response after 1 cycle.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared definitions for the data memory responder: access sizes, FSM states,
// the latched request payload and the alignment check.
package mem_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;
  localparam logic [1:0] SIZE_ILL  = 2'b11;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned CNT_W  = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  // Request fields captured at accept.
  typedef struct packed {
    logic              write;
    logic [1:0]        size;
    logic              sign;
    logic [DATA_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } mem_req_t;

  // Half needs addr[0]==0, word needs addr[1:0]==0; byte/illegal never misaligned.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    logic r;
    r = 1'b0;
    case (size)
      SIZE_HALF: r = addr_lo[0];
      SIZE_WORD: r = (addr_lo != 2'b00);
      default:   r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Big-endian lane steering between a 32-bit storage word and a sub-word access.
// Ports:
//   i_size     access size (byte/half/word/illegal)
//   i_addr_lo  byte offset inside the word
//   i_signed   sign-extend byte/half loads
//   i_wdata    right-justified store data
//   i_rword    storage word read at the access address
//   o_be_c     byte enables, bit 3 = bits [31:24] = lowest address
//   o_wword_c  store data shifted into its lanes
//   o_rdata_c  load result, right-justified and extended
module mem_lane_align
  import mem_pkg::*;
(
  input  logic [1:0]        i_size,
  input  logic [1:0]        i_addr_lo,
  input  logic              i_signed,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [DATA_W-1:0] i_rword,
  output logic [3:0]        o_be_c,
  output logic [DATA_W-1:0] o_wword_c,
  output logic [DATA_W-1:0] o_rdata_c
);

  logic [4:0]        w_shift;
  logic [DATA_W-1:0] w_rsh;

  // Lower addresses sit in higher lanes, so the shift is (3 - offset) bytes.
  always_comb begin
    w_shift   = 5'd0;
    o_be_c    = 4'b0000;
    o_rdata_c = '0;
    case (i_size)
      SIZE_BYTE: begin
        w_shift = {~i_addr_lo, 3'b000};
        o_be_c  = 4'b0001 << ~i_addr_lo;
      end
      SIZE_HALF: begin
        w_shift = {~i_addr_lo[1], 4'b0000};
        o_be_c  = i_addr_lo[1] ? 4'b0011 : 4'b1100;
      end
      SIZE_WORD: begin
        w_shift = 5'd0;
        o_be_c  = 4'b1111;
      end
      default: begin
        w_shift = 5'd0;
        o_be_c  = 4'b0000;
      end
    endcase

    o_wword_c = i_wdata << w_shift;
    w_rsh     = i_rword >> w_shift;

    case (i_size)
      SIZE_BYTE: o_rdata_c = {{24{i_signed & w_rsh[7]}}, w_rsh[7:0]};
      SIZE_HALF: o_rdata_c = {{16{i_signed & w_rsh[15]}}, w_rsh[15:0]};
      SIZE_WORD: o_rdata_c = i_rword;
      default:   o_rdata_c = '0;
    endcase
  end

endmodule

// File: rtl/data_mem_responder.sv
// Memory-side responder for datapath loads/stores with a fixed wait-state count.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   req_valid/req_ready request handshake; ready only while idle
//   req_write/size/signed/addr/wdata  request payload
//   rsp_valid/rsp_ready response handshake
//   rsp_rdata/rsp_err   load data (0 for stores/errors), error flag
//   busy                a transaction is in flight
module data_mem_responder
  import mem_pkg::*;
#(
  parameter int unsigned DEPTH_BYTES = 1024,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [DATA_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              busy
);

  localparam int unsigned DEPTH_WORDS = DEPTH_BYTES / 4;
  localparam int unsigned AW          = $clog2(DEPTH_WORDS);

  state_e            r_state, w_state_nxt;
  logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
  mem_req_t          r_req, w_req_in, w_req;
  logic              w_accept, w_commit, w_err;
  logic [AW-1:0]     w_widx;
  logic [DATA_W-1:0] w_rword, w_wword, w_load;
  logic [3:0]        w_be;

  logic              r_req_ready, r_rsp_valid, r_busy, r_rsp_err;
  logic [DATA_W-1:0] r_rsp_rdata;

  // Storage has no reset: contents survive rst.
  logic [DATA_W-1:0] r_mem [DEPTH_WORDS];

  // With zero wait states the commit happens on the accept edge, so the
  // access must use the live request rather than the latched copy.
  always_comb begin
    w_req_in = '{write: req_write, size: req_size, sign: req_signed,
                 addr: req_addr, wdata: req_wdata};
    w_req    = (r_state == IDLE) ? w_req_in : r_req;
    w_err    = (w_req.size == SIZE_ILL)
             || is_misaligned(w_req.size, w_req.addr[1:0])
             || (w_req.addr >= 32'(DEPTH_BYTES));
    w_widx   = w_req.addr[AW+1:2];
    w_rword  = r_mem[w_widx];
  end

  mem_lane_align u_align (
    .i_size    (w_req.size),
    .i_addr_lo (w_req.addr[1:0]),
    .i_signed  (w_req.sign),
    .i_wdata   (w_req.wdata),
    .i_rword   (w_rword),
    .o_be_c    (w_be),
    .o_wword_c (w_wword),
    .o_rdata_c (w_load)
  );

  // Next-state logic; w_commit marks the edge that enters RESP.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_accept    = 1'b0;
    w_commit    = 1'b0;
    case (r_state)
      IDLE: begin
        if (req_valid) begin
          w_accept  = 1'b1;
          w_cnt_nxt = CNT_W'(WAIT_CYCLES);
          if (WAIT_CYCLES == 0) begin
            w_state_nxt = RESP;
            w_commit    = 1'b1;
          end else begin
            w_state_nxt = WAIT;
          end
        end
      end
      WAIT: begin
        w_cnt_nxt = r_cnt - CNT_W'(1);
        if (r_cnt == CNT_W'(1)) begin
          w_state_nxt = RESP;
          w_commit    = 1'b1;
        end
      end
      RESP: begin
        if (rsp_ready) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // State, request latch and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_req       <= '0;
      r_req_ready <= 1'b1;
      r_rsp_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_rsp_rdata <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      if (w_accept) r_req <= w_req_in;
      r_req_ready <= (w_state_nxt == IDLE);
      r_rsp_valid <= (w_state_nxt == RESP);
      r_busy      <= (w_state_nxt != IDLE);
      if (w_commit) begin
        r_rsp_err   <= w_err;
        r_rsp_rdata <= (w_err || w_req.write) ? '0 : w_load;
      end
    end
  end

  // Byte-masked store at commit; a reset on that edge drops the store.
  always_ff @(posedge clk) begin
    if (!rst && w_commit && w_req.write && !w_err) begin
      for (int b = 0; b < 4; b++) begin
        if (w_be[b]) r_mem[w_widx][8*b +: 8] <= w_wword[8*b +: 8];
      end
    end
  end

  assign req_ready = r_req_ready;
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;
  assign rsp_err   = r_rsp_err;
  assign busy      = r_busy;

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: three instances (1, 3 and 0 wait states)
// checked every cycle against a byte-array transaction model, plus literal
// expectations for the directed cases.
module tb_data_mem_responder;

  localparam int unsigned DEPTH = 1024;
  localparam int unsigned WC [3] = '{1, 3, 0};
  localparam logic [1:0] SB = 2'd0, SH = 2'd1, SWD = 2'd2, SX = 2'd3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst        [3];
  logic        req_valid  [3];
  logic        req_ready  [3];
  logic        req_write  [3];
  logic [1:0]  req_size   [3];
  logic        req_signed [3];
  logic [31:0] req_addr   [3];
  logic [31:0] req_wdata  [3];
  logic        rsp_valid  [3];
  logic        rsp_ready  [3];
  logic [31:0] rsp_rdata  [3];
  logic        rsp_err    [3];
  logic        busy       [3];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    data_mem_responder #(.DEPTH_BYTES(DEPTH), .WAIT_CYCLES(WC[g])) u_dut (
      .clk(clk), .rst(rst[g]),
      .req_valid(req_valid[g]), .req_ready(req_ready[g]),
      .req_write(req_write[g]), .req_size(req_size[g]), .req_signed(req_signed[g]),
      .req_addr(req_addr[g]), .req_wdata(req_wdata[g]),
      .rsp_valid(rsp_valid[g]), .rsp_ready(rsp_ready[g]),
      .rsp_rdata(rsp_rdata[g]), .rsp_err(rsp_err[g]), .busy(busy[g])
    );
  end

  int checks = 0;
  int errors = 0;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endfunction

  // ---------------- behavioural model ----------------
  logic [7:0]  mm     [3][DEPTH];
  bit          m_pend [3];
  bit          m_resp [3];
  int          m_due  [3];
  logic [31:0] m_rdata[3];
  logic        m_err  [3];
  logic        q_wr   [3];
  logic [1:0]  q_sz   [3];
  logic        q_sg   [3];
  logic [31:0] q_a    [3];
  logic [31:0] q_wd   [3];
  int          cyc = 0;

  // Perform the latched access on the byte array: big-endian, lowest address most significant.
  function automatic void commit(int k);
    int n;
    logic [31:0] v;
    n = (q_sz[k] == SB) ? 1 : (q_sz[k] == SH) ? 2 : (q_sz[k] == SWD) ? 4 : 0;
    m_resp[k] = 1'b1;
    if (n == 0 || (q_a[k] % n) != 0 || q_a[k] >= DEPTH) begin
      m_err[k]   = 1'b1;
      m_rdata[k] = '0;
      return;
    end
    m_err[k] = 1'b0;
    if (q_wr[k]) begin
      for (int i = 0; i < n; i++) mm[k][q_a[k] + i] = 8'(q_wd[k] >> (8 * (n - 1 - i)));
      m_rdata[k] = '0;
    end else begin
      v = '0;
      for (int i = 0; i < n; i++) v = (v << 8) | 32'(mm[k][q_a[k] + i]);
      if (n < 4 && q_sg[k] && v[8*n-1]) v = v - (32'd1 << (8 * n));
      m_rdata[k] = v;
    end
  endfunction

  always @(posedge clk) begin
    cyc++;
    for (int k = 0; k < 3; k++) begin
      if (rst[k]) begin
        m_pend[k] = 0; m_resp[k] = 0; m_rdata[k] = '0; m_err[k] = 1'b0;
      end else if (m_resp[k]) begin
        if (rsp_ready[k]) begin m_pend[k] = 0; m_resp[k] = 0; end
      end else if (m_pend[k]) begin
        if (cyc == m_due[k]) commit(k);
      end else if (req_valid[k]) begin
        q_wr[k] = req_write[k]; q_sz[k] = req_size[k]; q_sg[k] = req_signed[k];
        q_a[k] = req_addr[k];   q_wd[k] = req_wdata[k];
        m_pend[k] = 1;
        m_due[k]  = cyc + int'(WC[k]);
        if (WC[k] == 0) commit(k);
      end
    end
  end

  // Every-cycle comparison of all outputs of all instances.
  always @(negedge clk) begin
    if (cyc > 0) begin
      for (int k = 0; k < 3; k++) begin
        chk($sformatf("u%0d req_ready c%0d", k, cyc), 32'(req_ready[k]), 32'(!m_pend[k]));
        chk($sformatf("u%0d busy c%0d", k, cyc), 32'(busy[k]), 32'(m_pend[k]));
        chk($sformatf("u%0d rsp_valid c%0d", k, cyc), 32'(rsp_valid[k]), 32'(m_resp[k]));
        chk($sformatf("u%0d rsp_rdata c%0d", k, cyc), rsp_rdata[k], m_rdata[k]);
        chk($sformatf("u%0d rsp_err c%0d", k, cyc), 32'(rsp_err[k]), 32'(m_err[k]));
      end
    end
  end

  // ---------------- drivers ----------------
  // Called at a negedge with the instance idle; returns at a negedge after the response handshake.
  task automatic txn(input int k, input string nm, input logic wr, input logic [1:0] sz,
                     input logic sg, input logic [31:0] a, input logic [31:0] wd, input int hold,
                     output logic [31:0] rd, output logic er);
    int n;
    int lat;
    req_valid[k] = 1'b1; req_write[k] = wr; req_size[k] = sz;
    req_signed[k] = sg;  req_addr[k] = a;   req_wdata[k] = wd;
    n = 0;
    while (!req_ready[k] && n < 50) begin @(negedge clk); n++; end
    @(negedge clk);
    req_valid[k]  = 1'b0;
    req_write[k]  = 1'($urandom);       req_size[k]  = 2'($urandom);
    req_signed[k] = 1'($urandom);       req_addr[k]  = $urandom;
    req_wdata[k]  = $urandom;
    lat = 1;
    while (!rsp_valid[k] && lat < 40) begin @(negedge clk); lat++; end
    chk({nm, " latency"}, 32'(lat), 32'(1 + WC[k]));
    rd = rsp_rdata[k];
    er = rsp_err[k];
    for (int h = 0; h < hold; h++) begin
      chk($sformatf("%s req_ready hold%0d", nm, h), 32'(req_ready[k]), 32'd0);
      @(negedge clk);
    end
    rsp_ready[k] = 1'b1;
    @(negedge clk);
    rsp_ready[k] = 1'b0;
  endtask

  task automatic exp_txn(input int k, input string nm, input logic wr, input logic [1:0] sz,
                         input logic sg, input logic [31:0] a, input logic [31:0] wd,
                         input int hold, input logic [31:0] erd, input logic eer);
    logic [31:0] rd;
    logic er;
    txn(k, nm, wr, sz, sg, a, wd, hold, rd, er);
    chk({nm, " rdata"}, rd, erd);
    chk({nm, " err"}, 32'(er), 32'(eer));
  endtask

  initial begin
    logic [31:0] rd, a;
    logic er;
    logic [1:0] sz;
    int k, r;

    for (int i = 0; i < 3; i++) begin
      for (int j = 0; j < int'(DEPTH); j++) mm[i][j] = 8'h00;
      rst[i] = 1'b1; req_valid[i] = 1'b0; req_write[i] = 1'b0; req_size[i] = SB;
      req_signed[i] = 1'b0; req_addr[i] = '0; req_wdata[i] = '0; rsp_ready[i] = 1'b0;
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset req_ready", 32'(req_ready[0]), 32'd1);
    chk("reset rsp_valid", 32'(rsp_valid[0]), 32'd0);
    chk("reset busy", 32'(busy[0]), 32'd0);
    chk("reset rdata", rsp_rdata[0], 32'd0);
    chk("reset err", 32'(rsp_err[0]), 32'd0);
    for (int i = 0; i < 3; i++) rst[i] = 1'b0;

    // Word store/load and sub-word extensions.
    exp_txn(0, "sw 10",  1, SWD, 0, 32'h10, 32'hDEADBEEF, 0, 32'h0, 0);
    exp_txn(0, "lw 10",  0, SWD, 0, 32'h10, 32'h0, 0, 32'hDEADBEEF, 0);
    exp_txn(0, "lb 10",  0, SB, 1, 32'h10, 32'h0, 0, 32'hFFFFFFDE, 0);
    exp_txn(0, "lbu 13", 0, SB, 0, 32'h13, 32'h0, 0, 32'h000000EF, 0);
    exp_txn(0, "lh 12",  0, SH, 1, 32'h12, 32'h0, 0, 32'hFFFFBEEF, 0);
    exp_txn(0, "lhu 10", 0, SH, 0, 32'h10, 32'h0, 1, 32'h0000DEAD, 0);
    // Partial store preserves neighbours.
    exp_txn(0, "sb 11",  1, SB, 0, 32'h11, 32'h55, 0, 32'h0, 0);
    exp_txn(0, "lw 10b", 0, SWD, 1, 32'h10, 32'h0, 0, 32'hDE55BEEF, 0);
    // Error cases.
    exp_txn(0, "lw 12 misalign", 0, SWD, 0, 32'h12, 32'h0, 0, 32'h0, 1);
    exp_txn(0, "sw 20", 1, SWD, 0, 32'h20, 32'h0BADF00D, 0, 32'h0, 0);
    exp_txn(0, "sw 21 misalign", 1, SWD, 0, 32'h21, 32'h1, 0, 32'h0, 1);
    exp_txn(0, "lw 20", 0, SWD, 0, 32'h20, 32'h0, 0, 32'h0BADF00D, 0);
    exp_txn(0, "lw 400 range", 0, SWD, 0, 32'h400, 32'h0, 0, 32'h0, 1);
    exp_txn(0, "lh 11 misalign", 0, SH, 0, 32'h11, 32'h0, 0, 32'h0, 1);
    exp_txn(0, "size 11", 0, SX, 0, 32'h10, 32'h0, 0, 32'h0, 1);
    exp_txn(0, "lb 3ff edge", 0, SB, 0, 32'h3FF, 32'h0, 0, 32'h0, 0);
    // Response held off for three cycles.
    exp_txn(0, "lw hold", 0, SWD, 0, 32'h10, 32'h0, 3, 32'hDE55BEEF, 0);

    // Three wait states with a reset while the store is waiting.
    exp_txn(1, "w3 sw 8", 1, SWD, 0, 32'h8, 32'h11223344, 0, 32'h0, 0);
    req_valid[1] = 1'b1; req_write[1] = 1'b1; req_size[1] = SWD;
    req_addr[1] = 32'h8; req_wdata[1] = 32'hCAFEF00D;
    @(negedge clk);
    req_valid[1] = 1'b0;
    chk("w3 busy in wait", 32'(busy[1]), 32'd1);
    rst[1] = 1'b1;
    @(negedge clk);
    rst[1] = 1'b0;
    chk("w3 req_ready after rst", 32'(req_ready[1]), 32'd1);
    chk("w3 busy after rst", 32'(busy[1]), 32'd0);
    exp_txn(1, "w3 lw 8", 0, SWD, 0, 32'h8, 32'h0, 0, 32'h11223344, 0);

    // Zero wait states.
    exp_txn(2, "w0 sh 6", 1, SH, 0, 32'h6, 32'h0000A5C3, 0, 32'h0, 0);
    exp_txn(2, "w0 lh 6", 0, SH, 1, 32'h6, 32'h0, 0, 32'hFFFFA5C3, 0);
    exp_txn(2, "w0 lw 4", 0, SWD, 0, 32'h4, 32'h0, 2, 32'h0000A5C3, 0);

    // Randomised traffic, checked by the per-cycle model comparison.
    for (int i = 0; i < 240; i++) begin
      k  = (i % 4 == 3) ? 2 : (i % 8 == 5) ? 1 : 0;
      r  = int'($urandom_range(0, 9));
      sz = (r < 3) ? SB : (r < 6) ? SH : (r < 9) ? SWD : SX;
      if ($urandom_range(0, 15) == 0) a = DEPTH - 4 + $urandom_range(0, 7);
      else a = $urandom_range(0, 63);
      if ($urandom_range(0, 3) != 0) begin
        if (sz == SH) a[0] = 1'b0;
        if (sz == SWD) a[1:0] = 2'b00;
      end
      txn(k, $sformatf("rnd%0d", i), 1'($urandom), sz, 1'($urandom), a, $urandom,
          int'($urandom_range(0, 2)), rd, er);
    end

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
